// File: rtl/grant_locking_router.sv
// grant_locking_router
//
// Routes one TileLink Grant stream to two client ports, selected by client_id.
// Multi-beat Grants lock the route to one port until the final beat, so the
// beats of one burst are never split. A single registered buffer stage gives
// 1-cycle latency at full throughput: the entry can drain and reload in the
// same cycle.
//
// Optional feature (macro GRANT_ROUTER_CHECK_EN): sticky protocol checker on
// io_err. When the macro is undefined, io_err is tied to 0 and no check logic
// exists.
//
// Ports:
//   clk, reset                   clock, asynchronous active-low reset
//   io_in_valid / io_in_ready    input Grant handshake
//   io_in_bits_*                 input Grant beat fields
//   io_out_k_valid / _ready      output handshake, k = 0, 1
//   io_out_k_bits_*              routed beat fields (same buffer for both ports)
//   io_locked                    a multi-beat burst is in progress
//   io_lock_owner                output port owning the current lock
//   io_err                       sticky protocol error
module grant_locking_router #(
   parameter int unsigned N_BEATS = 8,
   parameter int unsigned BEAT_W  = 3,
   parameter int unsigned DATA_W  = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              io_in_valid,
   output logic              io_in_ready,
   input  logic [BEAT_W-1:0] io_in_bits_addr_beat,
   input  logic [1:0]        io_in_bits_client_xact_id,
   input  logic              io_in_bits_manager_xact_id,
   input  logic              io_in_bits_is_builtin_type,
   input  logic [3:0]        io_in_bits_g_type,
   input  logic [DATA_W-1:0] io_in_bits_data,
   input  logic              io_in_bits_client_id,
   output logic              io_out_0_valid,
   input  logic              io_out_0_ready,
   output logic [BEAT_W-1:0] io_out_0_bits_addr_beat,
   output logic [1:0]        io_out_0_bits_client_xact_id,
   output logic              io_out_0_bits_manager_xact_id,
   output logic              io_out_0_bits_is_builtin_type,
   output logic [3:0]        io_out_0_bits_g_type,
   output logic [DATA_W-1:0] io_out_0_bits_data,
   output logic              io_out_0_bits_client_id,
   output logic              io_out_1_valid,
   input  logic              io_out_1_ready,
   output logic [BEAT_W-1:0] io_out_1_bits_addr_beat,
   output logic [1:0]        io_out_1_bits_client_xact_id,
   output logic              io_out_1_bits_manager_xact_id,
   output logic              io_out_1_bits_is_builtin_type,
   output logic [3:0]        io_out_1_bits_g_type,
   output logic [DATA_W-1:0] io_out_1_bits_data,
   output logic              io_out_1_bits_client_id,
   output logic              io_locked,
   output logic              io_lock_owner,
   output logic              io_err
);

   localparam logic [BEAT_W-1:0] LastBeat = BEAT_W'(N_BEATS - 1);

   // Buffer entry
   logic              r_buf_valid;
   logic              r_buf_sel;
   logic [BEAT_W-1:0] r_buf_addr_beat;
   logic [1:0]        r_buf_client_xact_id;
   logic              r_buf_manager_xact_id;
   logic              r_buf_is_builtin_type;
   logic [3:0]        r_buf_g_type;
   logic [DATA_W-1:0] r_buf_data;
   logic              r_buf_client_id;

   // Burst lock state
   logic [BEAT_W-1:0] r_cnt;
   logic              r_locked;
   logic              r_owner;

   logic w_multi;
   logic w_in_fire;
   logic w_out_fire;
   logic w_sel;

   always_comb begin
      w_multi = io_in_bits_is_builtin_type ? (io_in_bits_g_type == 4'h5)
                                           : (io_in_bits_g_type == 4'h0);
      // Only the port the buffered beat is headed to can stall the router.
      w_out_fire  = r_buf_valid & (r_buf_sel ? io_out_1_ready : io_out_0_ready);
      io_in_ready = ~r_buf_valid | w_out_fire;
      w_in_fire   = io_in_valid & io_in_ready;
      // While locked, client_id is ignored for routing.
      w_sel       = r_locked ? r_owner : io_in_bits_client_id;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_buf_valid           <= 1'b0;
         r_buf_sel             <= 1'b0;
         r_buf_addr_beat       <= '0;
         r_buf_client_xact_id  <= '0;
         r_buf_manager_xact_id <= 1'b0;
         r_buf_is_builtin_type <= 1'b0;
         r_buf_g_type          <= '0;
         r_buf_data            <= '0;
         r_buf_client_id       <= 1'b0;
      end else if (w_in_fire) begin
         r_buf_valid           <= 1'b1;
         r_buf_sel             <= w_sel;
         r_buf_addr_beat       <= io_in_bits_addr_beat;
         r_buf_client_xact_id  <= io_in_bits_client_xact_id;
         r_buf_manager_xact_id <= io_in_bits_manager_xact_id;
         r_buf_is_builtin_type <= io_in_bits_is_builtin_type;
         r_buf_g_type          <= io_in_bits_g_type;
         r_buf_data            <= io_in_bits_data;
         r_buf_client_id       <= io_in_bits_client_id;
      end else if (w_out_fire) begin
         r_buf_valid <= 1'b0;
      end
   end

   // Single-beat Grants never touch the lock or the counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt    <= '0;
         r_locked <= 1'b0;
         r_owner  <= 1'b0;
      end else if (w_in_fire && w_multi) begin
         r_cnt <= r_cnt + BEAT_W'(1);
         if (r_cnt == '0) begin
            r_locked <= 1'b1;
            r_owner  <= w_sel;
         end
         if (r_cnt == LastBeat) begin
            r_locked <= 1'b0;
         end
      end
   end

`ifdef GRANT_ROUTER_CHECK_EN
   logic r_err;
   logic w_err_set;

   always_comb begin
      w_err_set = 1'b0;
      if (w_in_fire) begin
         if (r_locked) begin
            w_err_set = (io_in_bits_client_id != r_owner) |
                        (io_in_bits_addr_beat != r_cnt) | ~w_multi;
         end else begin
            w_err_set = w_multi & (io_in_bits_addr_beat != '0);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_err <= 1'b0;
      end else if (w_err_set) begin
         r_err <= 1'b1;
      end
   end

   assign io_err = r_err;
`else
   assign io_err = 1'b0;
`endif

   always_comb begin
      io_out_0_valid                = r_buf_valid & ~r_buf_sel;
      io_out_1_valid                = r_buf_valid & r_buf_sel;
      io_out_0_bits_addr_beat       = r_buf_addr_beat;
      io_out_0_bits_client_xact_id  = r_buf_client_xact_id;
      io_out_0_bits_manager_xact_id = r_buf_manager_xact_id;
      io_out_0_bits_is_builtin_type = r_buf_is_builtin_type;
      io_out_0_bits_g_type          = r_buf_g_type;
      io_out_0_bits_data            = r_buf_data;
      io_out_0_bits_client_id       = r_buf_client_id;
      io_out_1_bits_addr_beat       = r_buf_addr_beat;
      io_out_1_bits_client_xact_id  = r_buf_client_xact_id;
      io_out_1_bits_manager_xact_id = r_buf_manager_xact_id;
      io_out_1_bits_is_builtin_type = r_buf_is_builtin_type;
      io_out_1_bits_g_type          = r_buf_g_type;
      io_out_1_bits_data            = r_buf_data;
      io_out_1_bits_client_id       = r_buf_client_id;
      io_locked                     = r_locked;
      io_lock_owner                 = r_owner;
   end

endmodule

// File: doc/grant_locking_router.md
Name: grant_locking_router

Overview:
- Receive-side counterpart of the two-input Grant locking arbiter: takes one TileLink Grant stream and routes each beat to one of two client ports selected by `client_id`.
- Multi-beat Grants are locked to a single output until the final beat, so beats of one burst are never split.
- One registered buffer stage sits between input and outputs (1-cycle latency, full throughput).
- Placed on the manager-to-client Grant path, upstream of the per-client Grant consumers.

Parameters:
- N_BEATS, 8: beats per multi-beat Grant; power of two, at least 2.
- BEAT_W, 3: width of `addr_beat` and of the beat counter; equals log2(N_BEATS).
- DATA_W, 64: Grant data width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- io_in_valid / io_in_ready  in / out  1 / 1  input Grant handshake
- io_in_bits_addr_beat  in  BEAT_W  beat index
- io_in_bits_client_xact_id  in  2  client transaction id
- io_in_bits_manager_xact_id  in  1  manager transaction id
- io_in_bits_is_builtin_type  in  1  built-in type flag
- io_in_bits_g_type  in  4  grant type
- io_in_bits_data  in  DATA_W  payload
- io_in_bits_client_id  in  1  destination select (0 → out_0, 1 → out_1)
- io_out_k_valid / io_out_k_ready  out / in  1 / 1  output handshake, k = 0, 1
- io_out_k_bits_*  out  (same widths as input)  routed beat fields, k = 0, 1
- io_locked  out  1  a multi-beat burst is in progress
- io_lock_owner  out  1  output port owning the current lock
- io_err  out  1  sticky protocol error (see Optional Feature)

Behaviour:
- Multi-beat beat: `is_builtin_type ? (g_type == 4'h5) : (g_type == 4'h0)`.
- `in_fire = io_in_valid & io_in_ready`.
- Buffer:
  - One entry: `buf_valid`, `buf_sel`, `buf_bits`.
  - `io_out_k_valid = buf_valid & (buf_sel == k)`; `io_out_k_bits = buf_bits` for both k.
  - `io_in_ready = !buf_valid | out_fire`, where `out_fire` is the handshake on the port `buf_sel` selects.
  - Load on `in_fire`; simultaneous drain and load in the same cycle is allowed (1 beat/cycle).
  - Latency: beat accepted in cycle t appears on its output in cycle t+1.
  - Backpressure on the non-selected output port never stalls the router.
- Routing select:
  - `sel = locked ? owner : io_in_bits_client_id`.
  - While locked, `client_id` is ignored for routing.
- Lock and counter (update only on `in_fire` of a multi-beat beat):
  - `cnt == 0`: set `locked = 1` and `owner = sel`.
  - Every such beat: `cnt <= cnt + 1`, width BEAT_W, wraps naturally.
  - `cnt == N_BEATS-1`: clear `locked`; cnt wraps to 0.
- Single-beat Grants: never lock, never touch `cnt`; routed purely by `client_id` when unlocked.
- A single-beat Grant arriving while locked is routed to `owner`. This is a protocol violation and is flagged only when the check is enabled.
- `io_locked = locked`; `io_lock_owner = owner`.
- Reset (asynchronous, reset low): `buf_valid = 0`, `buf_sel = 0`, `buf_bits = 0`, `cnt = 0`, `locked = 0`, `owner = 0`, `io_err = 0`.
  - All `io_out_k_valid` are 0 during and after reset.
  - `io_in_ready` is 1 in the first cycle after reset deassertion.
  - Reset mid-burst discards the buffered beat and the lock.
- No combinational path from `io_in_valid` to any output valid.
- `io_in_ready` depends combinationally on `io_out_k_ready` (drain-and-load).

Optional Feature:
- Macro: GRANT_ROUTER_CHECK_EN.
- Defined: on `in_fire` while `locked`, set sticky `io_err` if any of these hold:
  - `io_in_bits_client_id != owner`;
  - `io_in_bits_addr_beat != cnt`;
  - the beat is not multi-beat.
- Defined: on `in_fire` while unlocked, set `io_err` if a multi-beat beat has `addr_beat != 0`.
- `io_err` clears only on reset. Routing is unaffected by errors.
- Not defined: `io_err` is tied to 0 and no check logic is instantiated.

Test Plan:
- Single-beat to each port: builtin g_type=3, client_id=1, data=0xA5 → out_1 valid one cycle later with data 0xA5; out_0 stays invalid; `io_locked`=0.
- 8-beat burst, client_id=0, both outputs always ready → 8 consecutive beats on out_0, one per cycle, addr_beat 0..7; `io_locked`=1 from cycle after beat 0 until cycle after beat 7.
- Burst to out_1 with out_1 ready toggling 1/0 each cycle → `io_in_ready` follows the drain; all 8 beats in order with no loss or duplication; out_0 never valid.
- Back-to-back: 8-beat burst to port 0 immediately followed by single-beat to port 1 → 9th beat appears on out_1; counter back to 0.
- Reset asserted after 3 beats of a burst → outputs invalid, `io_locked`=0, `cnt`=0; a new single-beat with client_id=1 is then routed to out_1.
- (GRANT_ROUTER_CHECK_EN) Locked to 0, beat with client_id=1 → beat still goes to out_0; `io_err` rises and stays 1 until reset.
